// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter in front of a single vending credit/compare datapath.
// One buyer at a time owns a session; its coins accumulate into a shared credit
// register that either ends in a vend (with change) or a full refund.
module vend_session_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned PRICE   = 40,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     cancel,
    input  logic [N-1:0]     coin_valid,
    input  logic [5*N-1:0]   coin,
    output logic [N-1:0]     gnt,
    output logic             coin_ack,
    output logic             vend,
    output logic             change_valid,
    output logic [6:0]       change,
    output logic             busy
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0]      PriceC  = 7'(PRICE);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSession,
        StCheck,
        StVend,
        StRefund
    } state_e;

    state_e            state_q, state_d;
    logic [6:0]        credit_q, credit_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   gidx_q, gidx_d;
    logic [N-1:0]      gnt_q, gnt_d;

    // Inputs of the currently granted buyer; all other buyers are invisible.
    logic              g_req;
    logic              g_cancel;
    logic              g_cv;
    logic [4:0]        g_coin;

    // Round-robin pick, starting one past the buyer that finished last.
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;

    logic              coin_take;

    // Select the granted buyer's request, cancel and coin lanes.
    always_comb begin
        g_req    = 1'b0;
        g_cancel = 1'b0;
        g_cv     = 1'b0;
        g_coin   = 5'd0;
        for (int i = 0; i < int'(N); i++) begin
            if (gidx_q == IdxW'(i)) begin
                g_req    = req[i];
                g_cancel = cancel[i];
                g_cv     = coin_valid[i];
                g_coin   = coin[5*i +: 5];
            end
        end
    end

    // Search upward from last+1 (mod N) for the first requesting buyer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (int'(last_q) + k) % int'(N);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(idx);
            end
        end
    end

    // A coin is taken only in SESSION, and cancel or a dropped request beats it.
    always_comb begin
        coin_take = (state_q == StSession) && g_req && !g_cancel && g_cv && (g_coin != 5'd0);
    end

    // Next-state logic for the session FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        last_d   = last_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d  = StSession;
                    gidx_d   = pick_idx;
                    timer_d  = '0;
                    credit_d = '0;
                    for (int i = 0; i < int'(N); i++) begin
                        gnt_d[i] = (pick_idx == IdxW'(i));
                    end
                end
            end
            StSession: begin
                if (g_cancel || !g_req) begin
                    state_d = StRefund;
                end else if (coin_take) begin
                    // Credit cannot overflow: at most PRICE-1 plus one 5-bit coin.
                    credit_d = credit_q + {2'b00, g_coin};
                    timer_d  = '0;
                    state_d  = StCheck;
                end else if (timer_q == TmrLast) begin
                    state_d = StRefund;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCheck: begin
                state_d = (credit_q >= PriceC) ? StVend : StSession;
            end
            StVend, StRefund: begin
                credit_d = '0;
                last_d   = gidx_q;
                gnt_d    = '0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any open session silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            credit_q <= '0;
            timer_q  <= '0;
            last_q   <= LastRst;
            gidx_q   <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            last_q   <= last_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
        end
    end

    // Pulse outputs decode the current state; change is zero unless valid.
    always_comb begin
        gnt          = gnt_q;
        busy         = (state_q != StIdle);
        coin_ack     = coin_take;
        vend         = (state_q == StVend);
        change_valid = (state_q == StVend) || (state_q == StRefund);
        change       = 7'd0;
        if (state_q == StVend) begin
            change = credit_q - PriceC;
        end else if (state_q == StRefund) begin
            change = credit_q;
        end
    end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed plus randomized bench for vend_session_arbiter, checked every cycle
// against a transaction-level model of buyer sessions.
module tb_vend_session_arbiter;

    localparam int N       = 2;
    localparam int PRICE   = 40;
    localparam int TIMEOUT = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   cancel;
    logic [N-1:0]   coin_valid;
    logic [5*N-1:0] coin;
    logic [N-1:0]   gnt;
    logic           coin_ack;
    logic           vend;
    logic           change_valid;
    logic [6:0]     change;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the session: who owns it, what they paid, how it will end.
    int   m_owner;   // -1 when nobody holds a session
    int   m_credit;
    int   m_quiet;   // session cycles since grant or last accepted coin
    int   m_last;
    int   m_close;   // 0 open, 1 ends in vend, 2 ends in refund
    bit   m_chk;     // credit is being compared against the price this cycle
    bit   m_ended;

    logic [N-1:0] e_gnt;
    logic         e_busy, e_vend, e_cv, e_ack;
    logic [6:0]   e_change;

    always #5 clk = ~clk;

    vend_session_arbiter #(
        .N       (N),
        .PRICE   (PRICE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .cancel       (cancel),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .gnt          (gnt),
        .coin_ack     (coin_ack),
        .vend         (vend),
        .change_valid (change_valid),
        .change       (change),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_credit = 0;
        m_quiet  = 0;
        m_last   = N - 1;
        m_close  = 0;
        m_chk    = 1'b0;
        m_ended  = 1'b0;
    endtask

    task automatic model_outputs();
        int c;
        e_gnt    = '0;
        e_busy   = (m_owner >= 0);
        e_vend   = (m_close == 1);
        e_cv     = (m_close != 0);
        e_change = (m_close == 1) ? 7'(m_credit - PRICE) : (m_close == 2) ? 7'(m_credit) : 7'd0;
        e_ack    = 1'b0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            c = int'(coin[5*m_owner +: 5]);
            e_ack = (m_close == 0) && !m_chk && !cancel[m_owner] && req[m_owner]
                    && coin_valid[m_owner] && (c != 0);
        end
    endtask

    task automatic model_advance();
        m_ended = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (m_owner < 0 && req[idx]) m_owner = idx;
            end
            m_credit = 0;
            m_quiet  = 0;
        end else if (m_close != 0) begin
            m_last   = m_owner;
            m_owner  = -1;
            m_credit = 0;
            m_close  = 0;
            m_ended  = 1'b1;
        end else if (m_chk) begin
            m_chk = 1'b0;
            if (m_credit >= PRICE) m_close = 1;
        end else if (cancel[m_owner] || !req[m_owner]) begin
            m_close = 2;
        end else if (e_ack) begin
            m_credit += int'(coin[5*m_owner +: 5]);
            m_quiet  = 0;
            m_chk    = 1'b1;
        end else if (m_quiet == TIMEOUT - 1) begin
            m_close = 2;
        end else begin
            m_quiet++;
        end
    endtask

    task automatic check_outputs();
        chk("gnt",          32'(gnt),          32'(e_gnt));
        chk("busy",         32'(busy),         32'(e_busy));
        chk("coin_ack",     32'(coin_ack),     32'(e_ack));
        chk("vend",         32'(vend),         32'(e_vend));
        chk("change_valid", 32'(change_valid), 32'(e_cv));
        chk("change",       32'(change),       32'(e_change));
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_outputs();
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // Hold a coin on buyer b until it is accepted (bounded).
    task automatic feed(input int b, input int v);
        bit got;
        got = 1'b0;
        coin_valid[b]   = 1'b1;
        coin[5*b +: 5]  = 5'(v);
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (e_ack) got = 1'b1;
        end
        coin_valid[b] = 1'b0;
    endtask

    // Run until the session closes, then withdraw every request.
    task automatic run_until_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (m_ended) break;
        end
        req    = '0;
        cancel = '0;
    endtask

    task automatic idle_inputs();
        req        = '0;
        cancel     = '0;
        coin_valid = '0;
        coin       = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();

        // Outputs under reset.
        @(negedge clk);
        model_outputs();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b1;

        // Buyer0 pays 20+20: exact price, zero change.
        req = 2'b01;
        step();
        feed(0, 20);
        feed(0, 20);
        run_until_done(10);
        step();

        // Buyer0 pays 10+20+20: change of 10.
        req = 2'b01;
        feed(0, 10);
        feed(0, 20);
        feed(0, 20);
        run_until_done(10);
        step();

        // Both buyers request and cancel continuously: grants must alternate.
        req    = 2'b11;
        cancel = 2'b11;
        for (int i = 0; i < 14; i++) step();
        idle_inputs();
        step();
        step();

        // Buyer1 pays 5 then goes quiet; buyer0's coin must be ignored; timeout refund.
        req = 2'b10;
        step();
        step();
        feed(1, 5);
        coin_valid[0] = 1'b1;
        coin[4:0]     = 5'd7;
        run_until_done(40);
        idle_inputs();
        step();

        // Cancel and coin in the same cycle with credit 25.
        req = 2'b01;
        feed(0, 20);
        feed(0, 5);
        step();
        cancel[0]     = 1'b1;
        coin_valid[0] = 1'b1;
        coin[4:0]     = 5'd10;
        run_until_done(10);
        idle_inputs();
        step();

        // Reset in the middle of a session holding 30.
        req = 2'b01;
        feed(0, 20);
        feed(0, 10);
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        model_outputs();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        feed(0, 20);
        feed(0, 20);
        run_until_done(10);
        idle_inputs();
        step();

        // Random traffic, requests mostly held, occasional cancels and zero coins.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) begin
                req[b]        = ($urandom_range(0, 7) != 0);
                cancel[b]     = ($urandom_range(0, 23) == 0);
                coin_valid[b] = ($urandom_range(0, 2) == 0);
                coin[5*b +: 5] = 5'($urandom_range(0, 31));
            end
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
